// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_ctrl
// Description : Sequencer for an external combinational ALU. It captures an
//               operation on start, applies it cnt+1 times and feeds each
//               result back as the X operand. It then publishes the final
//               result, the zero flag and a one-cycle done pulse. Illegal
//               function codes skip execution and raise err with done.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] op,
    input  logic [7:0] opa,
    input  logic [7:0] opb,
    input  logic [2:0] cnt,
    output logic [3:0] alus,
    output logic [7:0] alu_x,
    output logic [7:0] alu_bus,
    input  logic [7:0] alu_dout,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] result,
    output logic       zf
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_EXEC   = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;
    localparam logic [3:0] c_OP_MAX = 4'd10;

    logic [1:0] r_state;
    logic [3:0] r_op_reg;
    logic [7:0] r_x_reg;
    logic [7:0] r_b_reg;
    logic [2:0] r_rem;
    logic       r_err_reg;
    logic [7:0] r_result;
    logic       r_zf;

    logic       w_in_exec;
    logic       w_in_done;

    assign w_in_exec = (r_state == c_EXEC);
    assign w_in_done = (r_state == c_DONE);

    // ALU operands are forced to zero whenever the ALU is not being used
    assign alus    = w_in_exec ? r_op_reg : 4'h0;
    assign alu_x   = w_in_exec ? r_x_reg  : 8'h00;
    assign alu_bus = w_in_exec ? r_b_reg  : 8'h00;

    assign busy    = (r_state != c_IDLE);
    assign done    = w_in_done;
    assign err     = w_in_done & r_err_reg;
    assign result  = r_result;
    assign zf      = r_zf;

    // State machine and datapath registers; start is only honoured in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_op_reg  <= 4'h0;
            r_x_reg   <= 8'h00;
            r_b_reg   <= 8'h00;
            r_rem     <= 3'd0;
            r_err_reg <= 1'b0;
            r_result  <= 8'h00;
            r_zf      <= 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (op <= c_OP_MAX) begin
                            r_op_reg <= op;
                            r_x_reg  <= opa;
                            r_b_reg  <= opb;
                            r_rem    <= cnt;
                            r_state  <= c_EXEC;
                        end else begin
                            // Illegal code: report immediately, keep result/zf
                            r_err_reg <= 1'b1;
                            r_state   <= c_DONE;
                        end
                    end
                end
                c_EXEC: begin
                    // Feed each pass back as X; bus operand stays constant
                    r_x_reg <= alu_dout;
                    if (r_rem != 3'd0) begin
                        r_rem <= r_rem - 3'd1;
                    end else begin
                        r_result  <= alu_dout;
                        r_zf      <= (alu_dout == 8'h00);
                        r_err_reg <= 1'b0;
                        r_state   <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_ctrl
// Description : Self-checking bench for alu_exec_ctrl with a combinational
//               ALU model, a vector table and a completion scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] op;
    logic [7:0] opa;
    logic [7:0] opb;
    logic [2:0] cnt;
    logic [3:0] alus;
    logic [7:0] alu_x;
    logic [7:0] alu_bus;
    logic [7:0] alu_dout;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] result;
    logic       zf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0] op;
        logic [7:0] opa;
        logic [7:0] opb;
        logic [2:0] cnt;
        logic [7:0] res;
        logic       zf;
        logic       err;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic       zf;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[15];

    logic [7:0] last_res = 8'h00;
    logic       last_zf  = 1'b1;

    alu_exec_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .cnt      (cnt),
        .alus     (alus),
        .alu_x    (alu_x),
        .alu_bus  (alu_bus),
        .alu_dout (alu_dout),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .result   (result),
        .zf       (zf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU
    function automatic logic [7:0] alu_f(input logic [3:0] f, input logic [7:0] x, input logic [7:0] b);
        case (f)
            4'd0:    return 8'h00;
            4'd1:    return x + b;
            4'd2:    return x - b;
            4'd3:    return x + 8'd1;
            4'd4:    return x - 8'd1;
            4'd5:    return x & b;
            4'd6:    return x | b;
            4'd7:    return ~x;
            4'd8:    return x ^ b;
            4'd9:    return {x[6:0], 1'b0};
            4'd10:   return b;
            default: return 8'h00;
        endcase
    endfunction

    always_comb alu_dout = alu_f(alus, alu_x, alu_bus);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Completion monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            chk("done_alus", 32'(alus), 32'h0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("result", 32'(result), 32'(mon_e.res));
                chk("zf", 32'(zf), 32'(mon_e.zf));
                chk("err", 32'(err), 32'(mon_e.err));
                chk("latency", 32'(cyc), 32'(mon_e.cyc));
            end
        end else begin
            chk("err_low", 32'(err), 32'h0);
        end
    end

    task automatic chk_idle(input string nm);
        chk({nm, "_busy"}, 32'(busy), 32'h0);
        chk({nm, "_alus"}, 32'(alus), 32'h0);
        chk({nm, "_alux"}, 32'(alu_x), 32'h0);
        chk({nm, "_alubus"}, 32'(alu_bus), 32'h0);
    endtask

    task automatic wait_empty(input string nm);
        for (int t = 0; t < 12 && sb.size() != 0; t++) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    // One operation: drive, push expectation, check each EXEC cycle
    task automatic run_op(input vec_t v);
        exp_t       e;
        logic       legal;
        logic [7:0] xm;
        legal = (v.op <= 4'd10);
        @(negedge clk);
        chk_idle("pre");
        start = 1'b1; op = v.op; opa = v.opa; opb = v.opb; cnt = v.cnt;
        e.res = v.res; e.zf = v.zf; e.err = v.err;
        e.cyc = cyc + 1 + (legal ? int'(v.cnt) + 1 : 0);
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        if (legal) begin
            xm = v.opa;
            for (int k = 0; k <= int'(v.cnt); k++) begin
                @(negedge clk);
                chk("exec_busy", 32'(busy), 32'h1);
                chk("exec_alus", 32'(alus), 32'(v.op));
                chk("exec_alux", 32'(alu_x), 32'(xm));
                chk("exec_bus", 32'(alu_bus), 32'(v.opb));
                chk("exec_hold", 32'(result), 32'(last_res));
                xm = alu_f(v.op, xm, v.opb);
            end
        end
        wait_empty("op");
        last_res = v.res;
        last_zf  = v.zf;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{4'h1, 8'h3C, 8'h05, 3'd0, 8'h41, 1'b0, 1'b0};
        vecs[1]  = '{4'hC, 8'h11, 8'h22, 3'd0, 8'h41, 1'b0, 1'b1};
        vecs[2]  = '{4'h9, 8'h03, 8'h00, 3'd3, 8'h30, 1'b0, 1'b0};
        vecs[3]  = '{4'h2, 8'h07, 8'h07, 3'd0, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{4'h3, 8'hFF, 8'h00, 3'd0, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{4'h5, 8'hF0, 8'h3C, 3'd0, 8'h30, 1'b0, 1'b0};
        vecs[6]  = '{4'h6, 8'hF0, 8'h0F, 3'd1, 8'hFF, 1'b0, 1'b0};
        vecs[7]  = '{4'h7, 8'h55, 8'h00, 3'd1, 8'h55, 1'b0, 1'b0};
        vecs[8]  = '{4'h8, 8'hAA, 8'hFF, 3'd2, 8'h55, 1'b0, 1'b0};
        vecs[9]  = '{4'h4, 8'h00, 8'h00, 3'd0, 8'hFF, 1'b0, 1'b0};
        vecs[10] = '{4'hA, 8'h12, 8'h34, 3'd0, 8'h34, 1'b0, 1'b0};
        vecs[11] = '{4'h0, 8'h77, 8'h00, 3'd0, 8'h00, 1'b1, 1'b0};
        vecs[12] = '{4'hF, 8'h01, 8'h01, 3'd0, 8'h00, 1'b1, 1'b1};
        vecs[13] = '{4'h1, 8'h80, 8'h80, 3'd7, 8'h80, 1'b0, 1'b0};
        vecs[14] = '{4'hB, 8'h00, 8'h00, 3'd2, 8'h80, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; op = 4'h0; opa = 8'h00; opb = 8'h00; cnt = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        chk("reset_result", 32'(result), 32'h0);
        chk("reset_zf", 32'(zf), 32'h1);

        // Reset wins over start on the same edge
        start = 1'b1; op = 4'h1; opa = 8'h01; opb = 8'h01; cnt = 3'd0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_over_start_busy", 32'(busy), 32'h0);
        rst = 1'b0; start = 1'b0;

        for (int i = 0; i < 15; i++) run_op(vecs[i]);

        // Back-to-back: start held high across two operations
        begin
            exp_t e;
            int   e0;
            @(negedge clk);
            e0 = cyc + 1;
            start = 1'b1; op = 4'hA; opa = 8'h00; opb = 8'h5A; cnt = 3'd0;
            e = '{8'h5A, 1'b0, 1'b0, e0 + 1};
            sb.push_back(e);
            e = '{8'h42, 1'b0, 1'b0, e0 + 4};
            sb.push_back(e);
            @(posedge clk);
            #1 op = 4'h9; opa = 8'h21; opb = 8'h00;
            repeat (3) @(posedge clk);
            #1 start = 1'b0;
            wait_empty("b2b");
            last_res = 8'h42; last_zf = 1'b0;
        end

        // Start pulsed during EXEC must be ignored
        begin
            exp_t e;
            @(negedge clk);
            start = 1'b1; op = 4'h1; opa = 8'h10; opb = 8'h01; cnt = 3'd2;
            e = '{8'h13, 1'b0, 1'b0, cyc + 1 + 3};
            sb.push_back(e);
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            start = 1'b1; op = 4'h1; opa = 8'hFF; opb = 8'hFF; cnt = 3'd0;
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            chk("busy_start_x", 32'(alu_x), 32'h12);
            chk("busy_start_bus", 32'(alu_bus), 32'h01);
            wait_empty("busy_start");
            repeat (4) @(negedge clk);
            chk("busy_start_idle", 32'(busy), 32'h0);
            chk("busy_start_result", 32'(result), 32'h13);
        end

        // Reset in the third EXEC cycle: no completion, registers cleared
        @(negedge clk);
        start = 1'b1; op = 4'h3; opa = 8'h10; opb = 8'h00; cnt = 3'd5;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("midrst_exec_alux", 32'(alu_x), 32'h12);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle("midrst");
        chk("midrst_done", 32'(done), 32'h0);
        chk("midrst_result", 32'(result), 32'h0);
        chk("midrst_zf", 32'(zf), 32'h1);
        repeat (10) @(negedge clk);
        chk("midrst_still_idle", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
